alu_sequencer: RTL and testbench

Multi-cycle controller that sits between instruction issue and the shared combinational ALU. It accepts one operation request at a time and evaluates its ARM condition code against an internal NZCV flag register. It drives the ALU operands and control for one or more beats, latches results and flags, and returns one response per beat. Load-multiple (LDM) requests expand into one address-generation beat per set bit of a 16-bit register list.

---
 rtl/alu_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller between instruction issue and a shared
// combinational ALU. Evaluates ARM condition codes against an internal NZCV
// register, drives registered ALU operands for one or more beats, and returns
// one response per beat. LDM expands into one address beat per set list bit.
module alu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [3:0]  req_cond,
  input  logic        req_s,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [15:0] req_reglist,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_reg,
  output logic        rsp_last,
  output logic        rsp_skip,
  output logic        rsp_err,
  output logic [3:0]  flags
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_ORR = 4'b0011;
  localparam logic [3:0] OP_EOR = 4'b0100;
  localparam logic [3:0] OP_MOV = 4'b0101;
  localparam logic [3:0] OP_CMP = 4'b0110;
  localparam logic [3:0] OP_LDR = 4'b1000;
  localparam logic [3:0] OP_STR = 4'b1001;
  localparam logic [3:0] OP_LDM = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // ARM condition check against NZCV; code 1111 behaves as AL.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = cf;
      4'b0011: cond_pass = ~cf;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = cf & ~z;
      4'b1001: cond_pass = ~cf | z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = ~z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      default: cond_pass = 1'b1;
    endcase
  endfunction

  // Op codes with no ALU behaviour defined.
  function automatic logic op_is_err(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_MOV, OP_CMP,
      OP_LDR, OP_STR, OP_LDM: op_is_err = 1'b0;
      default:                op_is_err = 1'b1;
    endcase
  endfunction

  // Whether the executed op writes the flag register.
  function automatic logic op_sets_flags(input logic [3:0] op, input logic s);
    case (op)
      OP_CMP: op_sets_flags = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_MOV, OP_LDR: op_sets_flags = s;
      default: op_sets_flags = 1'b0;
    endcase
  endfunction

  // Index of the lowest set bit (0 when the list is empty).
  function automatic logic [3:0] lowest_bit(input logic [15:0] l);
    lowest_bit = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (l[i]) lowest_bit = 4'(i);
    end
  endfunction

  state_t      state_r, state_nxt_s;
  logic [3:0]  op_r;
  logic        s_r;
  logic [15:0] list_r;
  logic [3:0]  beat_r;
  logic [3:0]  flags_r;
  logic [31:0] alu_a_r, alu_b_r;
  logic [3:0]  alu_ctrl_r;
  logic        req_ready_r, rsp_valid_r, rsp_last_r, rsp_skip_r, rsp_err_r;
  logic [31:0] rsp_result_r;
  logic [3:0]  rsp_reg_r;

  logic        accept_s, skip_s, err_s, more_s;
  logic [3:0]  idx_s;
  logic [15:0] list_nxt_s;

  assign idx_s      = lowest_bit(list_r);
  assign list_nxt_s = list_r & (list_r - 16'd1);

  // Next-state decode and request classification.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    err_s       = op_is_err(req_op);
    skip_s      = err_s | ~cond_pass(req_cond, flags_r) |
                  ((req_op == OP_LDM) & (req_reglist == 16'd0));
    more_s      = (op_r == OP_LDM) & (list_r != 16'd0) & ~rsp_skip_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          if (skip_s) state_nxt_s = ST_RESP;
          else        state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: state_nxt_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          if (more_s) state_nxt_s = ST_EXEC;
          else        state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Request capture, ALU operand drive, response and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r         <= 4'd0;
      s_r          <= 1'b0;
      list_r       <= 16'd0;
      beat_r       <= 4'd0;
      flags_r      <= 4'd0;
      alu_a_r      <= 32'd0;
      alu_b_r      <= 32'd0;
      alu_ctrl_r   <= 4'd0;
      req_ready_r  <= 1'b1;
      rsp_valid_r  <= 1'b0;
      rsp_result_r <= 32'd0;
      rsp_reg_r    <= 4'd0;
      rsp_last_r   <= 1'b0;
      rsp_skip_r   <= 1'b0;
      rsp_err_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r        <= req_op;
            s_r         <= req_s;
            beat_r      <= 4'd0;
            req_ready_r <= 1'b0;
            if (skip_s) begin
              list_r       <= 16'd0;
              rsp_valid_r  <= 1'b1;
              rsp_result_r <= 32'd0;
              rsp_reg_r    <= 4'd0;
              rsp_last_r   <= 1'b1;
              rsp_skip_r   <= 1'b1;
              rsp_err_r    <= err_s;
            end else begin
              list_r     <= req_reglist;
              alu_a_r    <= req_a;
              alu_b_r    <= (req_op == OP_LDM) ? 32'd0 : req_b;
              alu_ctrl_r <= req_op;
            end
          end
        end
        ST_EXEC: begin
          rsp_valid_r  <= 1'b1;
          rsp_result_r <= alu_result;
          rsp_skip_r   <= 1'b0;
          rsp_err_r    <= 1'b0;
          if (op_r == OP_LDM) begin
            rsp_reg_r  <= idx_s;
            list_r     <= list_nxt_s;
            rsp_last_r <= (list_nxt_s == 16'd0);
          end else begin
            rsp_reg_r  <= 4'd0;
            list_r     <= 16'd0;
            rsp_last_r <= 1'b1;
          end
          if (op_sets_flags(op_r, s_r)) flags_r <= alu_flags;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            if (more_s) begin
              // Next LDM beat: offset is 4 * beat index.
              beat_r  <= beat_r + 4'd1;
              alu_b_r <= {26'd0, beat_r + 4'd1, 2'b00};
            end else begin
              req_ready_r <= 1'b1;
            end
          end
        end
        default: begin
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_r;
  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign alu_ctrl   = alu_ctrl_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_result = rsp_result_r;
  assign rsp_reg    = rsp_reg_r;
  assign rsp_last   = rsp_last_r;
  assign rsp_skip   = rsp_skip_r;
  assign rsp_err    = rsp_err_r;
  assign flags      = flags_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a behavioural ALU closes the loop, expected
// responses are queued when a request is issued and compared on each handshake.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready, req_s;
  logic [3:0]  req_op, req_cond;
  logic [31:0] req_a, req_b;
  logic [15:0] req_reglist;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_ctrl, alu_flags;
  logic        rsp_valid, rsp_ready, rsp_last, rsp_skip, rsp_err;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_reg, flags;

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  rreg;
    logic        last;
    logic        skip;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_cond(req_cond), .req_s(req_s), .req_a(req_a), .req_b(req_b),
    .req_reglist(req_reglist),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_reg(rsp_reg), .rsp_last(rsp_last), .rsp_skip(rsp_skip),
    .rsp_err(rsp_err), .flags(flags)
  );

  // Behavioural ALU: NZCV with ARM carry (no-borrow) semantics for subtraction.
  always_comb begin
    logic [32:0] sum;
    logic c, v;
    sum = 33'd0; c = 1'b0; v = 1'b0;
    case (alu_ctrl)
      4'b0000, 4'b1000, 4'b1001, 4'b1010: begin
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        c = sum[32];
        v = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
      end
      4'b0001, 4'b0110: begin
        sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        c = sum[32];
        v = (alu_a[31] != alu_b[31]) && (sum[31] != alu_a[31]);
      end
      4'b0010: sum = {1'b0, alu_a & alu_b};
      4'b0011: sum = {1'b0, alu_a | alu_b};
      4'b0100: sum = {1'b0, alu_a ^ alu_b};
      4'b0101: sum = {1'b0, alu_b};
      default: sum = 33'd0;
    endcase
    alu_result = sum[31:0];
    alu_flags  = {sum[31], sum[31:0] == 32'd0, c, v};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_rsp(input logic [31:0] r, input logic [3:0] g,
                            input logic l, input logic s, input logic e);
    exp_t x;
    x.result = r; x.rreg = g; x.last = l; x.skip = s; x.err = e;
    sb.push_back(x);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [3:0] cond, input logic s,
                       input logic [31:0] a, input logic [31:0] b, input logic [15:0] rl);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("issue_ready", {31'd0, req_ready}, 32'd1);
    req_op = op; req_cond = cond; req_s = s; req_a = a; req_b = b; req_reglist = rl;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Waits (bounded) for a response, compares it with the queue head, handshakes.
  task automatic get_rsp(input string tag, input int exp_wait);
    int n = 0;
    exp_t e;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_wait));
    chk({tag, "_sb"}, {31'd0, sb.size() != 0}, 32'd1);
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    chk({tag, "_result"}, rsp_result, e.result);
    chk({tag, "_reg"}, {28'd0, rsp_reg}, {28'd0, e.rreg});
    chk({tag, "_last"}, {31'd0, rsp_last}, {31'd0, e.last});
    chk({tag, "_skip"}, {31'd0, rsp_skip}, {31'd0, e.skip});
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_flags"}, {28'd0, flags}, 32'd0);
    chk({tag, "_alu_a"}, alu_a, 32'd0);
    chk({tag, "_alu_b"}, alu_b, 32'd0);
    chk({tag, "_alu_ctrl"}, {28'd0, alu_ctrl}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_result"}, rsp_result, 32'd0);
    chk({tag, "_rsp_reg"}, {28'd0, rsp_reg}, 32'd0);
    chk({tag, "_rsp_bits"}, {29'd0, rsp_last, rsp_skip, rsp_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = 4'd0; req_cond = 4'd0; req_s = 1'b0;
    req_a = 32'd0; req_b = 32'd0; req_reglist = 16'd0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // ADD 0xFFFFFFFF + 1 with S: result 0, flags Z,C.
    expect_rsp(32'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    issue(4'b0000, 4'b1110, 1'b1, 32'hFFFF_FFFF, 32'd1, 16'd0);
    chk("add_exec_a", alu_a, 32'hFFFF_FFFF);
    chk("add_exec_b", alu_b, 32'd1);
    chk("add_exec_ready", {31'd0, req_ready}, 32'd0);
    get_rsp("add", 1);
    chk("add_flags", {28'd0, flags}, 32'h6);

    // SUB 1 - 2 with S: negative, borrow.
    expect_rsp(32'hFFFF_FFFF, 4'd0, 1'b1, 1'b0, 1'b0);
    issue(4'b0001, 4'b1110, 1'b1, 32'd1, 32'd2, 16'd0);
    get_rsp("sub", 1);
    chk("sub_flags", {28'd0, flags}, 32'h8);

    // EOR under MI (true), no S: flags untouched.
    expect_rsp(32'h0000_0FF0, 4'd0, 1'b1, 1'b0, 1'b0);
    issue(4'b0100, 4'b0100, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 16'd0);
    get_rsp("eor", 1);
    chk("eor_flags", {28'd0, flags}, 32'h8);

    // ADD under PL (false): skipped.
    expect_rsp(32'd0, 4'd0, 1'b1, 1'b1, 1'b0);
    issue(4'b0000, 4'b0101, 1'b1, 32'd3, 32'd4, 16'd0);
    get_rsp("pl_skip", 0);
    chk("pl_skip_flags", {28'd0, flags}, 32'h8);

    // CMP 5,5 always loads flags.
    expect_rsp(32'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    issue(4'b0110, 4'b1110, 1'b0, 32'd5, 32'd5, 16'd0);
    get_rsp("cmp", 1);
    chk("cmp_flags", {28'd0, flags}, 32'h6);

    // ADD under NE after Z=1: skipped, one-cycle latency.
    expect_rsp(32'd0, 4'd0, 1'b1, 1'b1, 1'b0);
    issue(4'b0000, 4'b0001, 1'b1, 32'd1, 32'd1, 16'd0);
    get_rsp("ne_skip", 0);
    chk("ne_skip_flags", {28'd0, flags}, 32'h6);

    // ADD under EQ executes; MOV under GT is skipped.
    expect_rsp(32'd5, 4'd0, 1'b1, 1'b0, 1'b0);
    issue(4'b0000, 4'b0000, 1'b0, 32'd2, 32'd3, 16'd0);
    get_rsp("eq_add", 1);
    expect_rsp(32'd0, 4'd0, 1'b1, 1'b1, 1'b0);
    issue(4'b0101, 4'b1100, 1'b0, 32'd0, 32'h1234, 16'd0);
    get_rsp("gt_skip", 0);

    // LDM base 0x1000, list 0x8025, with backpressure on the second beat.
    expect_rsp(32'h1000, 4'd0, 1'b0, 1'b0, 1'b0);
    expect_rsp(32'h1004, 4'd2, 1'b0, 1'b0, 1'b0);
    expect_rsp(32'h1008, 4'd5, 1'b0, 1'b0, 1'b0);
    expect_rsp(32'h100C, 4'd15, 1'b1, 1'b0, 1'b0);
    issue(4'b1010, 4'b1110, 1'b1, 32'h1000, 32'hDEAD_BEEF, 16'h8025);
    chk("ldm_exec_ctrl", {28'd0, alu_ctrl}, 32'hA);
    chk("ldm_exec_a", alu_a, 32'h1000);
    chk("ldm_exec_b", alu_b, 32'd0);
    get_rsp("ldm0", 1);
    chk("ldm1_exec_b", alu_b, 32'd4);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_result", rsp_result, sb[0].result);
      chk("bp_reg", {28'd0, rsp_reg}, {28'd0, sb[0].rreg});
      chk("bp_last", {31'd0, rsp_last}, 32'd0);
      @(negedge clk);
    end
    get_rsp("ldm1", 0);
    get_rsp("ldm2", 1);
    get_rsp("ldm3", 1);
    chk("ldm_flags", {28'd0, flags}, 32'h6);

    // Unimplemented op and empty LDM list.
    expect_rsp(32'd0, 4'd0, 1'b1, 1'b1, 1'b1);
    issue(4'b0111, 4'b1110, 1'b1, 32'd1, 32'd2, 16'd0);
    get_rsp("err", 0);
    expect_rsp(32'd0, 4'd0, 1'b1, 1'b1, 1'b0);
    issue(4'b1010, 4'b1110, 1'b0, 32'h2000, 32'd0, 16'd0);
    get_rsp("ldm_empty", 0);
    chk("err_flags", {28'd0, flags}, 32'h6);

    // STR with S set never updates flags.
    expect_rsp(32'd30, 4'd0, 1'b1, 1'b0, 1'b0);
    issue(4'b1001, 4'b1110, 1'b1, 32'd10, 32'd20, 16'd0);
    get_rsp("str", 1);
    chk("str_flags", {28'd0, flags}, 32'h6);

    // Reset during EXEC of the second LDM beat.
    expect_rsp(32'h2000, 4'd0, 1'b0, 1'b0, 1'b0);
    issue(4'b1010, 4'b1110, 1'b0, 32'h2000, 32'd0, 16'h0003);
    get_rsp("ldmr0", 1);
    chk("ldmr1_exec_b", alu_b, 32'd4);
    rst_n = 1'b0;
    #1;
    check_reset("mid_rst");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    expect_rsp(32'd15, 4'd0, 1'b1, 1'b0, 1'b0);
    issue(4'b0000, 4'b1110, 1'b1, 32'd7, 32'd8, 16'd0);
    get_rsp("post_rst_add", 1);
    chk("post_rst_flags", {28'd0, flags}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
